// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU-control decoder and MDU sequencer.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ULA_ADD   = 2'b00,
    ULA_BEQ   = 2'b01,
    ULA_RTYPE = 2'b10,
    ULA_ITYPE = 2'b11
  } ula_op_e;

  localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20, F_ADDU  = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24, F_XOR   = 6'h26, F_SLT  = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_XORI  = 6'h0E;

  typedef enum logic [2:0] {
    SEL_PASS = 3'b000,
    SEL_ADD  = 3'b001,
    SEL_SUB  = 3'b010,
    SEL_AND  = 3'b011,
    SEL_INC  = 3'b100,
    SEL_NOT  = 3'b101,
    SEL_XOR  = 3'b110,
    SEL_CMP  = 3'b111
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // mult/multu/div/divu occupy funct 0x18..0x1B
  function automatic logic is_mdu_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu_sel_decode.sv
// Combinational ALU selector / recognised-flag / overflow-trap decode.
// Optional: ALU_CTRL_OVF_TRAP_EN enables the signed-overflow trap decode.
module alu_sel_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPSEL_W = 3
) (
  input  logic [1:0]         ula_op,
  input  logic [5:0]         funct,
  input  logic [5:0]         opcode,
  output logic [OPSEL_W-1:0] ula_sel,
  output logic               recognised,
  output logic               ovf_trap_en
);

  alu_sel_e sel;

  always_comb begin
    sel        = SEL_ADD;
    recognised = 1'b1;
    case (ula_op)
      ULA_ADD: sel = SEL_ADD;
      ULA_BEQ: sel = SEL_SUB;
      ULA_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU, F_MULT, F_MULTU, F_DIV, F_DIVU: sel = SEL_ADD;
          F_SUB, F_SUBU:                                 sel = SEL_SUB;
          F_AND:                                         sel = SEL_AND;
          F_XOR:                                         sel = SEL_XOR;
          F_SLT, F_SLTU:                                 sel = SEL_CMP;
          default:                                       recognised = 1'b0;
        endcase
      end
      default: begin
        case (opcode)
          OP_ADDI, OP_ADDIU: sel = SEL_ADD;
          OP_ANDI:           sel = SEL_AND;
          OP_XORI:           sel = SEL_XOR;
          OP_SLTI, OP_SLTIU: sel = SEL_CMP;
          default:           recognised = 1'b0;
        endcase
      end
    endcase
  end

  always_comb begin
    ula_sel      = '0;
    ula_sel[2:0] = sel;
  end

`ifdef ALU_CTRL_OVF_TRAP_EN
  assign ovf_trap_en = ((ula_op == ULA_RTYPE) && ((funct == F_ADD) || (funct == F_SUB))) ||
                       ((ula_op == ULA_ITYPE) && (opcode == OP_ADDI));
`else
  assign ovf_trap_en = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_mdu_seq.sv
// ALU-control decode plus counter-driven sequencer for multi-cycle mult/div.
// Optional: ALU_CTRL_OVF_TRAP_EN (see alu_sel_decode).
module alu_ctrl_mdu_seq
  import alu_ctrl_pkg::*;
#(
  parameter  int OPSEL_W   = 3,
  parameter  int MDU_ITERS = 32,
  localparam int CNT_W     = $clog2(MDU_ITERS) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         ula_op,
  input  logic [5:0]         funct,
  input  logic [5:0]         opcode,
  input  logic               op_valid,
  input  logic               abort,
  output logic [OPSEL_W-1:0] ula_sel,
  output logic               funct_err,
  output logic               mdu_busy,
  output logic               mdu_step,
  output logic [1:0]         mdu_kind,
  output logic               mdu_done,
  output logic               ovf_trap_en
);

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       kind_nxt;
  logic             recognised;
  logic             mdu_start;

  alu_sel_decode #(.OPSEL_W(OPSEL_W)) u_dec (
    .ula_op      (ula_op),
    .funct       (funct),
    .opcode      (opcode),
    .ula_sel     (ula_sel),
    .recognised  (recognised),
    .ovf_trap_en (ovf_trap_en)
  );

  assign mdu_start = op_valid && (ula_op == ULA_RTYPE) && is_mdu_funct(funct);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mdu_kind  <= 2'b00;
      funct_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mdu_kind <= kind_nxt;
      // only R/I-type decodes carry a funct/opcode that can be malformed
      if (op_valid && ula_op[1]) funct_err <= !recognised;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    kind_nxt  = mdu_kind;
    mdu_busy  = 1'b0;
    mdu_step  = 1'b0;
    mdu_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mdu_start) begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_W'(MDU_ITERS - 1);
          kind_nxt  = funct[1:0];
        end
      end
      ST_RUN: begin
        mdu_busy = 1'b1;
        mdu_step = 1'b1;
        // abort wins over the final iteration
        if (abort) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        mdu_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_mdu_seq.sv
// Directed bench: decode table, MDU sequencing, abort, reset, single-iteration build.
module tb_alu_ctrl_mdu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ula_op;
  logic [5:0] funct, opcode;
  logic       op_valid, abort, op_valid1, abort1;

  logic [2:0] ula_sel;
  logic       funct_err, mdu_busy, mdu_step, mdu_done, ovf_trap_en;
  logic [1:0] mdu_kind;

  logic [3:0] ula_sel1;
  logic       funct_err1, busy1, step1, done1, ovf1;
  logic [1:0] kind1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_ctrl_mdu_seq dut (
    .clk(clk), .reset(reset), .ula_op(ula_op), .funct(funct), .opcode(opcode),
    .op_valid(op_valid), .abort(abort), .ula_sel(ula_sel), .funct_err(funct_err),
    .mdu_busy(mdu_busy), .mdu_step(mdu_step), .mdu_kind(mdu_kind), .mdu_done(mdu_done),
    .ovf_trap_en(ovf_trap_en)
  );

  alu_ctrl_mdu_seq #(.OPSEL_W(4), .MDU_ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .ula_op(ula_op), .funct(funct), .opcode(opcode),
    .op_valid(op_valid1), .abort(abort1), .ula_sel(ula_sel1), .funct_err(funct_err1),
    .mdu_busy(busy1), .mdu_step(step1), .mdu_kind(kind1), .mdu_done(done1),
    .ovf_trap_en(ovf1)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] f;
    logic [5:0] oc;
    logic       q;
    logic [2:0] sel;
    logic       err;
    logic       ovf;
  } vec_t;

  localparam int NV = 19;
  localparam vec_t TAB [NV] = '{
    '{2'b00, 6'h00, 6'h00, 1'b0, 3'b001, 1'b0, 1'b0},
    '{2'b01, 6'h00, 6'h00, 1'b0, 3'b010, 1'b0, 1'b0},
    '{2'b10, 6'h26, 6'h00, 1'b1, 3'b110, 1'b0, 1'b0},
    '{2'b10, 6'h3F, 6'h00, 1'b1, 3'b001, 1'b1, 1'b0},
    '{2'b10, 6'h24, 6'h00, 1'b1, 3'b011, 1'b0, 1'b0},
    '{2'b10, 6'h20, 6'h00, 1'b1, 3'b001, 1'b0, 1'b1},
    '{2'b10, 6'h21, 6'h00, 1'b1, 3'b001, 1'b0, 1'b0},
    '{2'b10, 6'h22, 6'h00, 1'b1, 3'b010, 1'b0, 1'b1},
    '{2'b10, 6'h23, 6'h00, 1'b1, 3'b010, 1'b0, 1'b0},
    '{2'b10, 6'h2A, 6'h00, 1'b1, 3'b111, 1'b0, 1'b0},
    '{2'b11, 6'h00, 6'h3F, 1'b1, 3'b001, 1'b1, 1'b0},
    '{2'b11, 6'h00, 6'h08, 1'b1, 3'b001, 1'b0, 1'b1},
    '{2'b11, 6'h00, 6'h09, 1'b1, 3'b001, 1'b0, 1'b0},
    '{2'b11, 6'h00, 6'h0C, 1'b1, 3'b011, 1'b0, 1'b0},
    '{2'b11, 6'h00, 6'h0E, 1'b1, 3'b110, 1'b0, 1'b0},
    '{2'b11, 6'h26, 6'h0A, 1'b1, 3'b111, 1'b0, 1'b0},
    '{2'b10, 6'h00, 6'h00, 1'b1, 3'b001, 1'b1, 1'b0},
    '{2'b10, 6'h1B, 6'h00, 1'b0, 3'b001, 1'b0, 1'b0},
    '{2'b01, 6'h00, 6'h00, 1'b0, 3'b010, 1'b0, 1'b0}
  };

  task automatic start_main(input logic [5:0] f);
    @(negedge clk);
    ula_op = 2'b10; funct = f; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; funct = 6'h20;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; abort = 1'b0; op_valid1 = 1'b0; abort1 = 1'b0;
    ula_op = 2'b00; funct = 6'h00; opcode = 6'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({mdu_busy, mdu_step, mdu_done, funct_err, mdu_kind} !== 6'b0) begin
      bad++; $display("FAIL reset_outs got=%b want=000000", {mdu_busy, mdu_step, mdu_done, funct_err, mdu_kind});
    end
    total++;
    if (ula_sel !== 3'b001) begin bad++; $display("FAIL reset_sel got=%b want=001", ula_sel); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (mdu_busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b want=0", mdu_busy); end
  endtask

  task automatic test_decode();
    vec_t v;
    logic exp_err, exp_ovf;
    exp_err = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      v = TAB[i];
      ula_op = v.op; funct = v.f; opcode = v.oc; op_valid = v.q;
      #1;
      total++;
      if (ula_sel !== v.sel) begin bad++; $display("FAIL dec_sel[%0d] got=%b want=%b", i, ula_sel, v.sel); end
      total++;
      if (ula_sel1 !== {1'b0, v.sel}) begin bad++; $display("FAIL dec_sel_w4[%0d] got=%b want=0%b", i, ula_sel1, v.sel); end
`ifdef ALU_CTRL_OVF_TRAP_EN
      exp_ovf = v.ovf;
`else
      exp_ovf = 1'b0;
`endif
      total++;
      if (ovf_trap_en !== exp_ovf) begin bad++; $display("FAIL dec_ovf[%0d] got=%b want=%b", i, ovf_trap_en, exp_ovf); end
      if (v.q) exp_err = v.err;
      @(posedge clk); #1;
      op_valid = 1'b0;
      total++;
      if (funct_err !== exp_err) begin bad++; $display("FAIL dec_err[%0d] got=%b want=%b", i, funct_err, exp_err); end
      total++;
      if (mdu_busy !== 1'b0) begin bad++; $display("FAIL dec_nostart[%0d] busy got=%b want=0", i, mdu_busy); end
    end
  endtask

  task automatic test_back_to_back();
    start_main(6'h1A);
    for (int i = 1; i <= 32; i++) begin
      total++;
      if (mdu_busy !== 1'b1 || mdu_step !== 1'b1 || mdu_done !== 1'b0 || mdu_kind !== 2'b10) begin
        bad++; $display("FAIL run_c%0d busy=%b step=%b done=%b kind=%b want 1 1 0 10", i, mdu_busy, mdu_step, mdu_done, mdu_kind);
      end
      if (i < 32) @(negedge clk);
    end
    @(negedge clk);
    abort = 1'b1; ula_op = 2'b10; funct = 6'h19; op_valid = 1'b1;
    #1;
    total++;
    if (mdu_done !== 1'b1 || mdu_busy !== 1'b0 || mdu_step !== 1'b0) begin
      bad++; $display("FAIL done_c33 done=%b busy=%b step=%b want 1 0 0", mdu_done, mdu_busy, mdu_step);
    end
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (mdu_done !== 1'b0 || mdu_busy !== 1'b0 || mdu_kind !== 2'b10) begin
      bad++; $display("FAIL idle_c34 done=%b busy=%b kind=%b want 0 0 10", mdu_done, mdu_busy, mdu_kind);
    end
    @(negedge clk);
    op_valid = 1'b0;
    total++;
    if (mdu_busy !== 1'b1 || mdu_kind !== 2'b01) begin
      bad++; $display("FAIL second_op busy=%b kind=%b want 1 01", mdu_busy, mdu_kind);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin
      bad++; $display("FAIL second_abort busy=%b done=%b want 0 0", mdu_busy, mdu_done);
    end
  endtask

  task automatic test_abort();
    logic seen_done, seen_busy;
    start_main(6'h19);
    for (int i = 1; i < 10; i++) begin
      if (i == 3) begin op_valid = 1'b1; funct = 6'h1B; end
      if (i == 4) begin
        op_valid = 1'b0;
        total++;
        if (mdu_kind !== 2'b01 || mdu_busy !== 1'b1) begin
          bad++; $display("FAIL run_ignore_opv kind=%b busy=%b want 01 1", mdu_kind, mdu_busy);
        end
      end
      @(negedge clk);
    end
    total++;
    if (mdu_step !== 1'b1) begin bad++; $display("FAIL abort_step10 got=%b want=1", mdu_step); end
    abort = 1'b1; op_valid = 1'b1; funct = 6'h1A;
    @(negedge clk);
    abort = 1'b0; op_valid = 1'b0;
    total++;
    if (mdu_busy !== 1'b0 || mdu_step !== 1'b0 || mdu_done !== 1'b0) begin
      bad++; $display("FAIL abort_idle busy=%b step=%b done=%b want 0 0 0", mdu_busy, mdu_step, mdu_done);
    end
    seen_done = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_done |= mdu_done; seen_busy |= mdu_busy;
    end
    total++;
    if (seen_done !== 1'b0 || seen_busy !== 1'b0) begin
      bad++; $display("FAIL abort_quiet done_seen=%b busy_seen=%b want 0 0", seen_done, seen_busy);
    end
  endtask

  task automatic test_abort_at_zero();
    logic seen_done;
    start_main(6'h1A);
    repeat (31) @(negedge clk);
    total++;
    if (mdu_busy !== 1'b1) begin bad++; $display("FAIL last_step busy got=%b want=1", mdu_busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (mdu_done !== 1'b0 || mdu_busy !== 1'b0) begin
      bad++; $display("FAIL abort_zero done=%b busy=%b want 0 0", mdu_done, mdu_busy);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen_done |= mdu_done;
    end
    total++;
    if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_zero_late done_seen=%b want 0", seen_done); end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    @(negedge clk);
    ula_op = 2'b10; funct = 6'h3F; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    total++;
    if (funct_err !== 1'b1 || mdu_kind !== 2'b10) begin
      bad++; $display("FAIL pre_reset err=%b kind=%b want 1 10", funct_err, mdu_kind);
    end
    reset = 1'b1;
    #1;
    total++;
    if (funct_err !== 1'b0 || mdu_kind !== 2'b00) begin
      bad++; $display("FAIL reset_err_kind err=%b kind=%b want 0 00", funct_err, mdu_kind);
    end
    @(negedge clk);
    reset = 1'b0;
    start_main(6'h18);
    repeat (4) @(negedge clk);
    total++;
    if (mdu_step !== 1'b1) begin bad++; $display("FAIL step5 got=%b want=1", mdu_step); end
    reset = 1'b1;
    #1;
    total++;
    if ({mdu_busy, mdu_step, mdu_done, funct_err, mdu_kind} !== 6'b0) begin
      bad++; $display("FAIL reset_async got=%b want=000000", {mdu_busy, mdu_step, mdu_done, funct_err, mdu_kind});
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= mdu_done | mdu_busy;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL post_reset activity=%b want 0", seen); end
  endtask

  task automatic test_iters1();
    @(negedge clk);
    ula_op = 2'b10; funct = 6'h1B; op_valid1 = 1'b1;
    @(negedge clk);
    op_valid1 = 1'b0;
    total++;
    if (busy1 !== 1'b1 || step1 !== 1'b1 || kind1 !== 2'b11 || done1 !== 1'b0) begin
      bad++; $display("FAIL it1_run busy=%b step=%b kind=%b done=%b want 1 1 11 0", busy1, step1, kind1, done1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || step1 !== 1'b0) begin
      bad++; $display("FAIL it1_done done=%b busy=%b step=%b want 1 0 0", done1, busy1, step1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b0) begin bad++; $display("FAIL it1_pulse done got=%b want=0", done1); end
    funct = 6'h18; op_valid1 = 1'b1;
    @(negedge clk);
    op_valid1 = 1'b0; abort1 = 1'b1;
    total++;
    if (busy1 !== 1'b1 || kind1 !== 2'b00) begin
      bad++; $display("FAIL it1_run2 busy=%b kind=%b want 1 00", busy1, kind1);
    end
    @(negedge clk);
    abort1 = 1'b0;
    total++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL it1_abort done=%b busy=%b want 0 0", done1, busy1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b0) begin bad++; $display("FAIL it1_abort_late done got=%b want=0", done1); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_abort();
    test_abort_at_zero();
    test_reset_mid_run();
    test_iters1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
